// File: rtl/rs_gf16_pkg.sv
// GF(2^4) arithmetic for the RS(15,13) codec, field polynomial x^4+x+1.
// Shared constants, log/antilog tables and multiply helper.
package rs_gf16_pkg;

  localparam int N             = 15;
  localparam int K             = 13;
  localparam int P             = N - K;
  localparam int SYMB_BITWIDTH = 4;

  typedef logic [SYMB_BITWIDTH-1:0] gf_t;

  localparam logic [4:0] PRIM_POLY = 5'b10011;

  // Entry 15 wraps back to alpha^0 so any 4-bit exponent is a legal index.
  localparam gf_t ALOG_TABLE [16] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1
  };

  // log(0) is undefined; its entry is never used by a valid decode.
  localparam gf_t LOG_TABLE [16] = '{
    4'd0,  4'd0,  4'd1,  4'd4,  4'd2,  4'd8,  4'd5,  4'd10,
    4'd3,  4'd14, 4'd9,  4'd7,  4'd6,  4'd13, 4'd11, 4'd12
  };

  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t acc;
    gf_t x;
    acc = '0;
    x   = a;
    for (int i = 0; i < SYMB_BITWIDTH; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? PRIM_POLY[3:0] : 4'h0);
    end
    return acc;
  endfunction

  function automatic gf_t gf_log(input gf_t a);
    return LOG_TABLE[a];
  endfunction

  function automatic gf_t gf_alog(input logic [3:0] e);
    return ALOG_TABLE[e];
  endfunction

endpackage

// File: rtl/rs_syndrome_n15k13.sv
// Combinational syndromes of a received RS(15,13) word: S0 = c(1), S1 = c(alpha).
module rs_syndrome_n15k13
  import rs_gf16_pkg::*;
(
  input  logic [N*SYMB_BITWIDTH-1:0] cw,
  output gf_t                        s0,
  output gf_t                        s1
);

  gf_t term0 [N];
  gf_t term1 [N];

  // Symbol k is the coefficient of x^(14-k), so it is weighted by alpha^(14-k).
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sym
      assign term0[gi] = cw[gi*SYMB_BITWIDTH +: SYMB_BITWIDTH];
      assign term1[gi] = gf_mul(cw[gi*SYMB_BITWIDTH +: SYMB_BITWIDTH], gf_alog(4'(N - 1 - gi)));
    end
  endgenerate

  always_comb begin
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < N; i++) begin
      s0 = s0 ^ term0[i];
      s1 = s1 ^ term1[i];
    end
  end

endmodule

// File: rtl/rs_decoder_n15k13.sv
// Three-stage RS(15,13) decoder: syndromes, single-error locate, correct.
// Also keeps saturating counters of corrected and uncorrectable words.
module rs_decoder_n15k13
  import rs_gf16_pkg::*;
#(
  parameter int CNT_BW = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N*SYMB_BITWIDTH-1:0]  cw_i,
  input  logic                        cw_valid_i,
  input  logic                        corr_en_i,
  input  logic                        cnt_clr_i,
  output logic [K*SYMB_BITWIDTH-1:0]  msg_o,
  output logic                        msg_valid_o,
  output logic                        corrected_o,
  output logic                        uncorr_o,
  output logic [3:0]                  err_sym_o,
  output logic [CNT_BW-1:0]           corr_cnt_o,
  output logic [CNT_BW-1:0]           uncorr_cnt_o
);

  localparam int CW_BW  = N * SYMB_BITWIDTH;
  localparam int MSG_BW = K * SYMB_BITWIDTH;

  gf_t s0_next;
  gf_t s1_next;

  rs_syndrome_n15k13 u_syndrome (
    .cw (cw_i),
    .s0 (s0_next),
    .s1 (s1_next)
  );

  logic             v1_reg;
  logic             ce1_reg;
  logic [CW_BW-1:0] cw1_reg;
  gf_t              s0_reg;
  gf_t              s1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg  <= 1'b0;
      ce1_reg <= 1'b0;
      cw1_reg <= '0;
      s0_reg  <= '0;
      s1_reg  <= '0;
    end else begin
      v1_reg <= cw_valid_i;
      if (cw_valid_i) begin
        ce1_reg <= corr_en_i;
        cw1_reg <= cw_i;
        s0_reg  <= s0_next;
        s1_reg  <= s1_next;
      end
    end
  end

  logic [4:0] pdiff_next;
  logic [3:0] k_next;
  logic       single_next;
  logic       uncorr_next;

  // Error position p = log(S1) - log(S0) mod 15, symbol index k = 14 - p.
  always_comb begin
    pdiff_next = 5'd15 + {1'b0, gf_log(s1_reg)} - {1'b0, gf_log(s0_reg)};
    if (pdiff_next >= 5'd15) pdiff_next = pdiff_next - 5'd15;
    single_next = (s0_reg != '0) && (s1_reg != '0);
    uncorr_next = (s0_reg == '0) != (s1_reg == '0);
    k_next      = single_next ? (4'd14 - pdiff_next[3:0]) : 4'd0;
  end

  logic             v2_reg;
  logic             ce2_reg;
  logic [CW_BW-1:0] cw2_reg;
  logic             single2_reg;
  logic             uncorr2_reg;
  logic [3:0]       k2_reg;
  gf_t              e2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg      <= 1'b0;
      ce2_reg     <= 1'b0;
      cw2_reg     <= '0;
      single2_reg <= 1'b0;
      uncorr2_reg <= 1'b0;
      k2_reg      <= '0;
      e2_reg      <= '0;
    end else begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        ce2_reg     <= ce1_reg;
        cw2_reg     <= cw1_reg;
        single2_reg <= single_next;
        uncorr2_reg <= uncorr_next;
        k2_reg      <= k_next;
        e2_reg      <= s0_reg;
      end
    end
  end

  logic [K-1:0]      fix_hit;
  logic [MSG_BW-1:0] msg_next;

  // Parity-symbol errors (k = 13, 14) never match here, so msg passes through.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_fix
      assign fix_hit[gi] = single2_reg && ce2_reg && (k2_reg == 4'(gi));
      assign msg_next[gi*SYMB_BITWIDTH +: SYMB_BITWIDTH] =
        cw2_reg[gi*SYMB_BITWIDTH +: SYMB_BITWIDTH] ^ (fix_hit[gi] ? e2_reg : 4'h0);
    end
  endgenerate

  logic              msg_valid_reg;
  logic [MSG_BW-1:0] msg_reg;
  logic              corrected_reg;
  logic              uncorr_reg;
  logic [3:0]        err_sym_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_valid_reg <= 1'b0;
      msg_reg       <= '0;
      corrected_reg <= 1'b0;
      uncorr_reg    <= 1'b0;
      err_sym_reg   <= '0;
    end else begin
      msg_valid_reg <= v2_reg;
      if (v2_reg) begin
        msg_reg       <= msg_next;
        corrected_reg <= single2_reg;
        uncorr_reg    <= uncorr2_reg;
        err_sym_reg   <= k2_reg;
      end else begin
        corrected_reg <= 1'b0;
        uncorr_reg    <= 1'b0;
        err_sym_reg   <= '0;
      end
    end
  end

  logic [CNT_BW-1:0] corr_cnt_reg;
  logic [CNT_BW-1:0] uncorr_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_reg   <= '0;
      uncorr_cnt_reg <= '0;
    end else if (cnt_clr_i) begin
      corr_cnt_reg   <= '0;
      uncorr_cnt_reg <= '0;
    end else begin
      if (msg_valid_reg && corrected_reg && (corr_cnt_reg != '1))
        corr_cnt_reg <= corr_cnt_reg + CNT_BW'(1);
      if (msg_valid_reg && uncorr_reg && (uncorr_cnt_reg != '1))
        uncorr_cnt_reg <= uncorr_cnt_reg + CNT_BW'(1);
    end
  end

  assign msg_o        = msg_reg;
  assign msg_valid_o  = msg_valid_reg;
  assign corrected_o  = corrected_reg;
  assign uncorr_o     = uncorr_reg;
  assign err_sym_o    = err_sym_reg;
  assign corr_cnt_o   = corr_cnt_reg;
  assign uncorr_cnt_o = uncorr_cnt_reg;

endmodule

// File: tb/tb_rs_decoder_n15k13.sv
// Directed and sweep bench for rs_decoder_n15k13 with an output scoreboard.
`timescale 1ns/1ps
module tb_rs_decoder_n15k13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [59:0] cw_i;
  logic        cw_valid_i;
  logic        corr_en_i;
  logic        cnt_clr_i;
  logic [51:0] msg_o;
  logic        msg_valid_o;
  logic        corrected_o;
  logic        uncorr_o;
  logic [3:0]  err_sym_o;
  logic [15:0] corr_cnt_o;
  logic [15:0] uncorr_cnt_o;

  rs_decoder_n15k13 #(.CNT_BW(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cw_i         (cw_i),
    .cw_valid_i   (cw_valid_i),
    .corr_en_i    (corr_en_i),
    .cnt_clr_i    (cnt_clr_i),
    .msg_o        (msg_o),
    .msg_valid_o  (msg_valid_o),
    .corrected_o  (corrected_o),
    .uncorr_o     (uncorr_o),
    .err_sym_o    (err_sym_o),
    .corr_cnt_o   (corr_cnt_o),
    .uncorr_cnt_o (uncorr_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [51:0] msg;
    logic        corr;
    logic        unc;
    logic [3:0]  k;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        mx;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] exp_corr = '0;
  logic [15:0] exp_unc  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bench-side GF(16) arithmetic, independent of the design package.
  function automatic logic [3:0] tb_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] x;
    r = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [3:0] tb_apow(input int n);
    logic [3:0] r;
    r = 4'h1;
    for (int i = 0; i < n; i++) r = tb_mul(r, 4'h2);
    return r;
  endfunction

  // Parity solves S0 = S1 = 0: p13 = (A+B)/(1+alpha), p14 = A + p13.
  function automatic logic [59:0] encode(input logic [51:0] m);
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] p13;
    a = 4'h0;
    b = 4'h0;
    for (int k = 0; k < 13; k++) begin
      a = a ^ m[k*4 +: 4];
      b = b ^ tb_mul(m[k*4 +: 4], tb_apow(14 - k));
    end
    p13 = tb_mul(a ^ b, 4'hE);
    return {a ^ p13, p13, m};
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [51:0] rnd_msg();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[51:0];
  endfunction

  task automatic send(input logic [59:0] cw, input logic ce, input logic [51:0] m,
                      input logic c, input logic u, input logic [3:0] k);
    exp_t x;
    @(negedge clk);
    cw_i       = cw;
    corr_en_i  = ce;
    cw_valid_i = 1'b1;
    x.msg = m;
    x.corr = c;
    x.unc = u;
    x.k = c ? k : 4'd0;
    x.due = cyc + 3;
    q.push_back(x);
    if (c) exp_corr = sat(exp_corr);
    if (u) exp_unc = sat(exp_unc);
  endtask

  task automatic idle(input int n);
    logic [63:0] r;
    repeat (n) begin
      @(negedge clk);
      r = {$urandom(), $urandom()};
      cw_i       = r[59:0];
      corr_en_i  = r[60];
      cw_valid_i = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && msg_valid_o) begin
      chk("out_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        mx = q.pop_front();
        chk("msg", 64'(msg_o), 64'(mx.msg));
        chk("corrected", 64'(corrected_o), 64'(mx.corr));
        chk("uncorr", 64'(uncorr_o), 64'(mx.unc));
        chk("err_sym", 64'(err_sym_o), 64'(mx.k));
        chk("latency", 64'(cyc), 64'(mx.due));
        $display("txn msg=%h corr=%0d unc=%0d k=%0d", msg_o, corrected_o, uncorr_o, err_sym_o);
      end
    end else if (rst_n) begin
      chk("idle_flags", 64'({corrected_o, uncorr_o, err_sym_o}), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [51:0] m;
    logic [59:0] cw;

    rst_n      = 1'b0;
    cw_i       = '0;
    cw_valid_i = 1'b0;
    corr_en_i  = 1'b0;
    cnt_clr_i  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(msg_valid_o), 64'd0);
    chk("rst_msg", 64'(msg_o), 64'd0);
    chk("rst_flags", 64'({corrected_o, uncorr_o, err_sym_o}), 64'd0);
    chk("rst_cnts", 64'({corr_cnt_o, uncorr_cnt_o}), 64'd0);
    rst_n = 1'b1;
    idle(2);

    send(60'h0, 1'b1, 52'h0, 1'b0, 1'b0, 4'd0);
    idle(1);
    send(60'h7 << 20, 1'b1, 52'h0, 1'b1, 1'b0, 4'd5);
    send(60'h7 << 20, 1'b0, 52'h7 << 20, 1'b1, 1'b0, 4'd5);
    send(60'h11, 1'b1, 52'h11, 1'b0, 1'b1, 4'd0);
    m = rnd_msg();
    cw = encode(m);
    cw[59:56] = cw[59:56] ^ 4'h3;
    send(cw, 1'b1, m, 1'b1, 1'b0, 4'd14);
    m = rnd_msg();
    send(encode(m), 1'b1, m, 1'b0, 1'b0, 4'd0);
    idle(6);
    chk("corr_cnt_directed", 64'(corr_cnt_o), 64'(exp_corr));
    chk("uncorr_cnt_directed", 64'(uncorr_cnt_o), 64'(exp_unc));

    for (int k = 0; k < 15; k++) begin
      for (int e = 1; e < 16; e++) begin
        m = rnd_msg();
        cw = encode(m);
        cw[k*4 +: 4] = cw[k*4 +: 4] ^ 4'(e);
        send(cw, 1'b1, m, 1'b1, 1'b0, 4'(k));
      end
    end
    idle(6);
    chk("corr_cnt_sweep", 64'(corr_cnt_o), 64'(exp_corr));
    chk("uncorr_cnt_sweep", 64'(uncorr_cnt_o), 64'(exp_unc));

    send(60'h9 << 8, 1'b1, 52'h0, 1'b1, 1'b0, 4'd2);
    idle(2);
    @(negedge clk);
    cnt_clr_i  = 1'b1;
    cw_valid_i = 1'b0;
    @(negedge clk);
    cnt_clr_i = 1'b0;
    exp_corr  = '0;
    exp_unc   = '0;
    chk("clr_priority_corr", 64'(corr_cnt_o), 64'd0);
    chk("clr_priority_uncorr", 64'(uncorr_cnt_o), 64'd0);

    force dut.corr_cnt_reg = 16'hFFFE;
    @(negedge clk);
    release dut.corr_cnt_reg;
    exp_corr = 16'hFFFE;
    send(60'h5, 1'b1, 52'h0, 1'b1, 1'b0, 4'd0);
    idle(6);
    chk("sat_reach", 64'(corr_cnt_o), 64'(exp_corr));
    send(60'h5, 1'b1, 52'h0, 1'b1, 1'b0, 4'd0);
    idle(6);
    chk("sat_hold", 64'(corr_cnt_o), 64'(exp_corr));

    m = rnd_msg();
    send(encode(m), 1'b1, m, 1'b0, 1'b0, 4'd0);
    send(60'h3 << 40, 1'b1, 52'h0, 1'b1, 1'b0, 4'd10);
    @(negedge clk);
    rst_n      = 1'b0;
    cw_valid_i = 1'b0;
    q.delete();
    exp_corr = '0;
    exp_unc  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_valid", 64'(msg_valid_o), 64'd0);
    end
    chk("rst_corr_cnt", 64'(corr_cnt_o), 64'(exp_corr));
    chk("rst_uncorr_cnt", 64'(uncorr_cnt_o), 64'(exp_unc));

    m = rnd_msg();
    cw = encode(m);
    cw[3:0] = cw[3:0] ^ 4'hF;
    send(cw, 1'b1, m, 1'b1, 1'b0, 4'd0);
    idle(6);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("corr_cnt_final", 64'(corr_cnt_o), 64'(exp_corr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
